bus_cycle_ctrl: RTL
===================

Name: bus_cycle_ctrl

Overview:
8085-style bus interface unit between the CPU core (`U1`) and the external multiplexed address/data bus.
- Takes one bus request at a time from the core: opcode fetch, memory read/write, or I/O read/write.
- Sequences the T-states: T1, T2, optional TW wait states, T3, and T4 for opcode fetch only.
- Drives `ALE`, `RDn`, `WRn`, `IO_Mn`, `S1`/`S0` and the multiplexed AD bus.
- Returns captured read data to the core's `data_in`.

Parameters:
- `ADDR_W`, 16, full address width; low 8 bits are multiplexed on the AD bus.
- `MAX_WAIT`, 15, wait-state limit before a bus-error abort.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `req`  in  1  core request, held until `ack`
- `cyc`  in  3  cycle type: FETCH, MEMRD, MEMWR, IORD, IOWR
- `addr`  in  `ADDR_W`  cycle address
- `wdata`  in  8  write data
- `ack`  out  1  request accepted; pulses in T1
- `done`  out  1  one-cycle pulse, cycle complete
- `rdata`  out  8  captured read data, to core `data_in`
- `bus_err`  out  1  one-cycle pulse on wait-state timeout
- `READY`  in  1  external ready, sampled on rising clk
- `ALE`  out  1  address latch enable
- `RDn`  out  1  read strobe, active low
- `WRn`  out  1  write strobe, active low
- `IO_Mn`  out  1  1 = I/O cycle, 0 = memory cycle
- `S1`  out  1  status bit 1
- `S0`  out  1  status bit 0
- `ADD`  out  `ADDR_W-8`  high address byte
- `AD_out`  out  8  AD bus drive value
- `AD_oe`  out  1  AD bus output enable
- `AD_in`  in  8  AD bus sampled value
- `state`  out  3  current T-state: IDLE=0, T1=1, T2=2, TW=3, T3=4, T4=5

Behaviour:
- Reset (async, immediate):
  - `state`=IDLE, `ALE`=0, `RDn`=`WRn`=1, `IO_Mn`=0, `S1S0`=00.
  - `AD_oe`=0, `ADD`=0, `rdata`=0, `ack`/`done`/`bus_err`=0.
  - Reset mid-cycle forces strobes high at once; the cycle is abandoned and there is no `done`.
- All outputs are registered except `ack`, which is high whenever `state`==T1.
- IDLE: `req`=1 at a rising edge latches `cyc`, `addr`, `wdata` and moves to T1.
- Status for the whole cycle, T1 through T3/T4:
  - FETCH: `IO_Mn`=0, `S1S0`=11
  - MEMRD: 0, 10
  - MEMWR: 0, 01
  - IORD: 1, 10
  - IOWR: 1, 01
- T1: `ALE`=1, `AD_oe`=1, `AD_out`=`addr[7:0]`, `ADD`=`addr[ADDR_W-1:8]`. `ADD` then holds through T3/T4.
- T2:
  - `ALE`=0.
  - Reads: `RDn`=0, `AD_oe`=0.
  - Writes: `WRn`=0, `AD_oe`=1, `AD_out`=`wdata`.
  - `READY` sampled at the edge ending T2: 1 goes to T3, 0 goes to TW.
- TW:
  - Strobes and status held.
  - `READY`=1 goes to T3.
  - On the `MAX_WAIT`-th consecutive TW with `READY`=0: go to IDLE, strobes high, `bus_err` pulse, no `done`.
- T3:
  - Strobes still low.
  - At the edge ending T3: reads capture `AD_in` into `rdata`, and `RDn`/`WRn` return to 1.
  - Non-FETCH cycles then go to IDLE; FETCH goes to T4.
- `done` is high for exactly the one cycle after T3; `rdata` is valid from that cycle until the next read's capture.
- T4 (FETCH only): no strobes, `AD_oe`=0, status held; next state is IDLE.
- Back-to-back: `req` high at the edge leaving T3 (non-FETCH) or T4 goes directly to T1, with no IDLE cycle.
- `req` is ignored in every state except IDLE and the last T-state of a cycle.
- Core must drop `req` after `ack`, otherwise the same request is reissued.
- Invalid `cyc` codes are treated as MEMRD.

Decomposition:
- Package `i8085_bus_pkg` holds:
  - `cyc_t` enum for the cycle types.
  - `tstate_t` enum: IDLE, T1, T2, TW, T3, T4.
  - Status constants: `ST_FETCH`=2'b11, `ST_READ`=2'b10, `ST_WRITE`=2'b01, `ST_HALT`=2'b00.
- Single module; no sub-module. The wait counter is an in-module register.

Test Plan:
- MEMRD, `addr`=16'h2034, `READY`=1, `AD_in`=8'hA5:
  - `state` 1,2,4,0; `ALE` high in T1 only; `AD_out`=34 in T1.
  - `RDn` low in T2–T3; `S1S0`=10; `IO_Mn`=0; `done` pulse; `rdata`=A5.
- FETCH, `addr`=16'h0000, `AD_in`=8'h3E:
  - T1–T4 with `S1S0`=11; `done` coincides with T4; `rdata`=3E; 4 T-states total.
- IOWR, `addr`=16'h0080, `wdata`=8'h5C, `READY` low for 2 samples:
  - Sequence T1,T2,TW,TW,T3.
  - `WRn` low T2 through T3; `AD_out`=5C, `AD_oe`=1 in T2–T3; `IO_Mn`=1; `S1S0`=01.
- Back-to-back: FETCH then MEMWR with `req` held:
  - T1 follows T4 directly, no IDLE cycle between.
  - `ack` pulses once per cycle; `done` pulses twice.
- `READY` stuck 0 with `MAX_WAIT`=15:
  - 15 TW cycles, then IDLE; `bus_err` pulse; `RDn`=1; no `done`.
- `rst` asserted mid-TW of a MEMRD:
  - Same timestep: `RDn`=1, `state`=0, `AD_oe`=0, `S1S0`=00.
  - After release, a new MEMRD completes normally.

Source files
------------

// File: rtl/i8085_bus_pkg.sv
// Shared types for the 8085-style bus cycle controller: cycle codes, T-states,
// status encodings and small decode helpers.
package i8085_bus_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH = 3'd0,
    CYC_MEMRD = 3'd1,
    CYC_MEMWR = 3'd2,
    CYC_IORD  = 3'd3,
    CYC_IOWR  = 3'd4
  } cyc_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5
  } tstate_t;

  localparam logic [1:0] ST_FETCH = 2'b11;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b00;

  // Unknown codes fall back to a plain memory read.
  function automatic cyc_t norm_cyc(input logic [2:0] c);
    case (c)
      3'd0:    return CYC_FETCH;
      3'd1:    return CYC_MEMRD;
      3'd2:    return CYC_MEMWR;
      3'd3:    return CYC_IORD;
      3'd4:    return CYC_IOWR;
      default: return CYC_MEMRD;
    endcase
  endfunction

  function automatic logic is_write(input cyc_t c);
    return (c == CYC_MEMWR) || (c == CYC_IOWR);
  endfunction

  // Returns {IO_Mn, S1, S0} for a cycle type.
  function automatic logic [2:0] status_of(input cyc_t c);
    case (c)
      CYC_FETCH: return {1'b0, ST_FETCH};
      CYC_MEMRD: return {1'b0, ST_READ};
      CYC_MEMWR: return {1'b0, ST_WRITE};
      CYC_IORD:  return {1'b1, ST_READ};
      CYC_IOWR:  return {1'b1, ST_WRITE};
      default:   return {1'b0, ST_READ};
    endcase
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// 8085-style bus interface unit: sequences T1/T2/TW/T3/T4 for one core request
// at a time and drives the multiplexed AD bus, strobes and status pins.
module bus_cycle_ctrl
  import i8085_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        cyc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              ack,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              bus_err,
  input  logic              READY,
  output logic              ALE,
  output logic              RDn,
  output logic              WRn,
  output logic              IO_Mn,
  output logic              S1,
  output logic              S0,
  output logic [ADDR_W-9:0] ADD,
  output logic [7:0]        AD_out,
  output logic              AD_oe,
  input  logic [7:0]        AD_in,
  output logic [2:0]        state
);

  localparam int WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  // Handshake: req is a level held by the core; ack is high for the single
  // T1 cycle and the request is sampled only in IDLE or the last T-state.
  tstate_t           st_q, st_d;
  cyc_t              cyc_q, cyc_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;

  logic              ale_d, rd_n_d, wr_n_d, io_m_d, ad_oe_d, done_d, err_d;
  logic [1:0]        s_d;
  logic [ADDR_W-9:0] add_d;
  logic [7:0]        ad_out_d, rdata_d;
  logic              start, go_idle;
  cyc_t              new_cyc;

  assign new_cyc = norm_cyc(cyc);
  assign ack     = (st_q == T1);
  assign state   = st_q;

  always_comb begin
    st_d     = st_q;
    cyc_d    = cyc_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ale_d    = 1'b0;
    rd_n_d   = RDn;
    wr_n_d   = WRn;
    io_m_d   = IO_Mn;
    s_d      = {S1, S0};
    add_d    = ADD;
    ad_out_d = AD_out;
    ad_oe_d  = AD_oe;
    rdata_d  = rdata;
    done_d   = 1'b0;
    err_d    = 1'b0;
    start    = 1'b0;
    go_idle  = 1'b0;

    case (st_q)
      IDLE: start = req;
      T1: begin
        st_d = T2;
        if (is_write(cyc_q)) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_q;
        end else begin
          rd_n_d  = 1'b0;
          ad_oe_d = 1'b0;
        end
      end
      T2: begin
        if (READY) begin
          st_d = T3;
        end else begin
          st_d  = TW;
          cnt_d = WCNT_W'(1);
        end
      end
      TW: begin
        if (READY) begin
          st_d = T3;
        end else if (cnt_q == WAIT_LIM) begin
          go_idle = 1'b1;
          err_d   = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + WCNT_W'(1);
        end
      end
      T3: begin
        done_d = 1'b1;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        if (!is_write(cyc_q)) rdata_d = AD_in;
        if (cyc_q == CYC_FETCH) begin
          st_d    = T4;
          ad_oe_d = 1'b0;
        end else if (req) begin
          start = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      T4: begin
        if (req) start = 1'b1;
        else     go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      st_d    = IDLE;
      ad_oe_d = 1'b0;
      io_m_d  = 1'b0;
      s_d     = ST_HALT;
    end

    // A new request overrides the return to IDLE, giving back-to-back cycles.
    if (start) begin
      st_d     = T1;
      cyc_d    = new_cyc;
      wdata_d  = wdata;
      ale_d    = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      ad_oe_d  = 1'b1;
      ad_out_d = addr[7:0];
      add_d    = addr[ADDR_W-1:8];
      {io_m_d, s_d} = status_of(new_cyc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      cyc_q   <= CYC_MEMRD;
      wdata_q <= '0;
      cnt_q   <= '0;
      ALE     <= 1'b0;
      RDn     <= 1'b1;
      WRn     <= 1'b1;
      IO_Mn   <= 1'b0;
      S1      <= 1'b0;
      S0      <= 1'b0;
      ADD     <= '0;
      AD_out  <= '0;
      AD_oe   <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      st_q    <= st_d;
      cyc_q   <= cyc_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ALE     <= ale_d;
      RDn     <= rd_n_d;
      WRn     <= wr_n_d;
      IO_Mn   <= io_m_d;
      S1      <= s_d[1];
      S0      <= s_d[0];
      ADD     <= add_d;
      AD_out  <= ad_out_d;
      AD_oe   <= ad_oe_d;
      rdata   <= rdata_d;
      done    <= done_d;
      bus_err <= err_d;
    end
  end

endmodule
